parity_frame_rx: RTL and testbench
==================================

PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

Interface
REQ-001: Parameter DATA_W, default 8, data bits per frame; legal range 1..16.
REQ-002: Parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity.
REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: sin  input  1  serial line bit, sampled only when sin_valid=1.
REQ-006: sin_valid  input  1  bit strobe; one frame bit per high cycle; may have gaps of any length.
REQ-007: data_out  output  DATA_W  last received data word, LSB received first.
REQ-008: data_valid  output  1  one-cycle pulse; a frame completed this cycle.
REQ-009: parity_err  output  1  parity status of the frame flagged by data_valid.
REQ-010: frame_err  output  1  stop-bit status of the frame flagged by data_valid.
REQ-011: busy  output  1  high while in any state other than IDLE.

Function
REQ-012: Frame format: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
REQ-013: FSM states are IDLE, DATA, PARITY and STOP; transitions occur only on cycles with sin_valid=1.
REQ-014: IDLE: sin=0 -> DATA, clear the bit counter and the parity accumulator; sin=1 -> stay in IDLE (line idle).
REQ-015: DATA: shift sin into the data shift register and XOR sin into the accumulator; after the DATA_W-th bit -> PARITY.
REQ-016: PARITY: XOR sin into the accumulator -> STOP.
REQ-017: Parity error when accumulator != PARITY_ODD after the parity bit.
REQ-018: STOP: in the same cycle, load data_out from the shift register, pulse data_valid=1 and latch parity_err and frame_err (frame_err = ~sin), then -> IDLE.
REQ-019: Latency: data_valid asserts in the cycle after the clock edge that samples the stop bit (registered output).
REQ-020: An errored frame still delivers data_out and data_valid; the error flags qualify it.
REQ-021: data_out, parity_err and frame_err hold their values until the next data_valid.
REQ-022: data_valid is high for exactly one cycle per frame, even if sin_valid stays high continuously.
REQ-023: Back-to-back frames are accepted: a start bit on the strobe after the stop bit is recognised with no idle bit required.
REQ-024: A frame_err frame returns to IDLE; a low stop bit is not treated as the next start bit.
REQ-025: Bit counter width is $clog2(DATA_W+1); it never wraps within a frame.

Reset
REQ-026: While rst_n=0, state=IDLE, counter=0, accumulator=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
REQ-027: Reset asserted mid-frame aborts the frame immediately, with no data_valid pulse.
REQ-028: After reset deasserts, the block awaits a fresh start bit.

Structure
REQ-029: Shared package parity_rx_pkg holds the state enum (IDLE, DATA, PARITY, STOP) and the default DATA_W constant.
REQ-030: One sub-module, parity_acc, holds the XOR accumulator (clear, enable, bit in, parity out), reusable by a future parity transmitter.
REQ-031: All outputs are driven from flops; there is no combinational path from sin to any output.

Verification
REQ-032: Even parity, byte 0xA5 (four ones), parity bit 0, stop 1 -> data_out=0xA5, data_valid pulse, parity_err=0, frame_err=0.
REQ-033: Byte 0x01 with parity bit 0 (wrong under even parity) -> data_out=0x01, parity_err=1, frame_err=0.
REQ-034: Byte 0x3C, correct parity, stop bit 0 -> frame_err=1, parity_err=0, state IDLE one cycle later.
REQ-035: rst_n pulsed low after 4 data bits -> no data_valid; a following clean 0x5A frame is received correctly.
REQ-036: Two frames (0xFF then 0x00) back-to-back, sin_valid held high -> exactly two data_valid pulses, values in order, no errors.
REQ-037: PARITY_ODD=1, byte 0x00 with parity bit 1 and random sin_valid gaps -> data_out=0x00, parity_err=0.

Source files
------------

// File: rtl/parity_rx_pkg.sv
// -----------------------------------------------------------------------------
// parity_rx_pkg
// Shared definitions for the parity-framed serial receiver and its helpers.
//   rx_state_t      : receiver FSM states (IDLE, DATA, PARITY, STOP)
//   DEFAULT_DATA_W  : default number of data bits per frame
//   cnt_width()     : width of a counter that must reach the value w
// -----------------------------------------------------------------------------
package parity_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int DEFAULT_DATA_W = 8;

  // The bit counter has to hold the value w itself (it counts up to the full
  // word length without wrapping), hence w+1 distinct values.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/parity_acc.sv
// -----------------------------------------------------------------------------
// parity_acc
// Running XOR accumulator over a serial bit stream. Kept separate so that a
// future parity transmitter can reuse the same block.
//   clk     : clock, state updates on rising edge
//   rst_n   : asynchronous active-low reset, clears the accumulator
//   clear   : synchronous clear (takes priority over enable)
//   enable  : fold bit_in into the accumulator this cycle
//   bit_in  : serial bit to accumulate
//   parity  : current XOR of all bits accumulated since the last clear
// -----------------------------------------------------------------------------
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output logic parity
);

  // Clear wins over enable so that a start-of-frame clear is never polluted
  // by a bit that happens to arrive on the same strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (clear) begin
      parity <= 1'b0;
    end else if (enable) begin
      parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// -----------------------------------------------------------------------------
// parity_frame_rx
// Serial frame receiver: start bit (0), DATA_W data bits LSB first, one
// parity bit, one stop bit (1). Bits arrive one per cycle in which sin_valid
// is high; arbitrary gaps between strobes are allowed.
//   Parameters
//     DATA_W      : data bits per frame (1..16)
//     PARITY_ODD  : 0 = even parity, 1 = odd parity
//   Ports
//     clk         : clock, all state updates on rising edge
//     rst_n       : asynchronous active-low reset
//     sin         : serial line bit, sampled only when sin_valid=1
//     sin_valid   : bit strobe
//     data_out    : last received data word (held until next frame)
//     data_valid  : one-cycle pulse, a frame completed
//     parity_err  : parity status of the frame flagged by data_valid
//     frame_err   : stop-bit status of the frame flagged by data_valid
//     busy        : high while a frame is in progress
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module parity_frame_rx
  import parity_rx_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              sin_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int                CNT_W        = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT     = CNT_W'(DATA_W - 1);
  localparam logic              PARITY_SENSE = (PARITY_ODD != 0);

  rx_state_t         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              acc_clear;
  logic              acc_enable;
  logic              acc_parity;

  // Bits arrive LSB first, so each new bit enters at the MSB end and the
  // register shifts right; after DATA_W bits the first one sits at bit 0.
  // Written without a part-select so that DATA_W=1 stays legal.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                 input logic              b);
    logic [DATA_W-1:0] nxt;
    nxt             = cur >> 1;
    nxt[DATA_W-1]   = b;
    return nxt;
  endfunction

  // The accumulator restarts on a recognised start bit and folds in every
  // data bit and the parity bit; the stop bit is deliberately excluded.
  assign acc_clear  = sin_valid && (state == IDLE) && !sin;
  assign acc_enable = sin_valid && ((state == DATA) || (state == PARITY));

  parity_acc u_parity_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .enable (acc_enable),
    .bit_in (sin),
    .parity (acc_parity)
  );

  // Receiver FSM with registered outputs. Nothing moves unless sin_valid is
  // high. On the stop bit the frame result is loaded into the output flops
  // and the FSM drops straight back to IDLE, so the strobe immediately after
  // the stop bit may already carry the next start bit. A low stop bit is
  // consumed as the stop bit (frame_err) and is never mistaken for a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (sin_valid) begin
        case (state)
          IDLE: begin
            if (!sin) begin
              state   <= DATA;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          DATA: begin
            shift_reg <= shift_in(shift_reg, sin);
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            state <= STOP;
          end
          STOP: begin
            data_out   <= shift_reg;
            data_valid <= 1'b1;
            parity_err <= (acc_parity != PARITY_SENSE);
            frame_err  <= !sin;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_rx
// Self-checking bench for parity_frame_rx. Two instances (even and odd
// parity, DATA_W=8) share the same serial input so every frame is judged
// under both parity senses by a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_parity_frame_rx;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              sin;
  logic              sin_valid;

  logic [DATA_W-1:0] data_out_e;
  logic              data_valid_e;
  logic              parity_err_e;
  logic              frame_err_e;
  logic              busy_e;

  logic [DATA_W-1:0] data_out_o;
  logic              data_valid_o;
  logic              parity_err_o;
  logic              frame_err_o;
  logic              busy_o;

  int checks    = 0;
  int failures  = 0;
  int pulses_e  = 0;
  int pulses_o  = 0;
  int exp_frames = 0;

  parity_frame_rx #(.DATA_W(DATA_W), .PARITY_ODD(0)) dut_even (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .data_out   (data_out_e),
    .data_valid (data_valid_e),
    .parity_err (parity_err_e),
    .frame_err  (frame_err_e),
    .busy       (busy_e)
  );

  parity_frame_rx #(.DATA_W(DATA_W), .PARITY_ODD(1)) dut_odd (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .data_out   (data_out_o),
    .data_valid (data_valid_o),
    .parity_err (parity_err_o),
    .frame_err  (frame_err_o),
    .busy       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count data_valid cycles; sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    if (data_valid_e) pulses_e++;
    if (data_valid_o) pulses_o++;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: a frame is a parity error when the number of ones over data
  // plus parity bit does not have the parity the receiver is configured for.
  function automatic logic exp_perr(input logic [DATA_W-1:0] d, input logic p,
                                    input int odd);
    return ((($countones(d) + int'(p)) % 2) != odd);
  endfunction

  // The parity bit that makes a frame correct under the given sense.
  function automatic logic good_pbit(input logic [DATA_W-1:0] d, input int odd);
    return (($countones(d) + odd) % 2) == 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one frame bit, optionally preceded by random idle (no strobe)
  // cycles carrying junk on sin. Returns at the next falling edge.
  task automatic applyStimulus(input logic b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      sin_valid = 1'b0;
      sin       = 1'($urandom);
      @(negedge clk);
    end
    sin       = b;
    sin_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_both(input string tag, input logic [DATA_W-1:0] d,
                            input logic pbit, input logic stop_b);
    checkOutput({tag, "_dv_even"},   16'(data_valid_e), 16'(1));
    checkOutput({tag, "_data_even"}, 16'(data_out_e),   16'(d));
    checkOutput({tag, "_perr_even"}, 16'(parity_err_e), 16'(exp_perr(d, pbit, 0)));
    checkOutput({tag, "_ferr_even"}, 16'(frame_err_e),  16'(!stop_b));
    checkOutput({tag, "_busy_even"}, 16'(busy_e),       16'(0));
    checkOutput({tag, "_dv_odd"},    16'(data_valid_o), 16'(1));
    checkOutput({tag, "_data_odd"},  16'(data_out_o),   16'(d));
    checkOutput({tag, "_perr_odd"},  16'(parity_err_o), 16'(exp_perr(d, pbit, 1)));
    checkOutput({tag, "_ferr_odd"},  16'(frame_err_o),  16'(!stop_b));
    checkOutput({tag, "_busy_odd"},  16'(busy_o),       16'(0));
  endtask

  // Send a full frame and check the result in the cycle after the stop bit.
  task automatic send_frame(input string tag, input logic [DATA_W-1:0] d,
                            input logic pbit, input logic stop_b,
                            input int max_gap, input bit hold_valid);
    applyStimulus(1'b0, max_gap);
    for (int i = 0; i < DATA_W; i++) applyStimulus(d[i], max_gap);
    applyStimulus(pbit, max_gap);
    applyStimulus(stop_b, max_gap);
    exp_frames++;
    check_both(tag, d, pbit, stop_b);
    if (!hold_valid) sin_valid = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic              p;
    logic              s;
    logic [DATA_W-1:0] mid;

    rst_n     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state, even with a start-looking line strobed during reset.
    checkOutput("rst_dv",        16'(data_valid_e), 16'(0));
    checkOutput("rst_busy",      16'(busy_e),       16'(0));
    checkOutput("rst_data",      16'(data_out_e),   16'(0));
    checkOutput("rst_perr",      16'(parity_err_e), 16'(0));
    checkOutput("rst_ferr",      16'(frame_err_e),  16'(0));
    checkOutput("rst_busy_odd",  16'(busy_o),       16'(0));
    checkOutput("rst_dv_odd",    16'(data_valid_o), 16'(0));
    sin_valid = 1'b0;
    sin       = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);

    // Clean 0xA5, even-correct parity.
    send_frame("a5", 8'hA5, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    checkOutput("a5_pulse_end", 16'(data_valid_e), 16'(0));
    checkOutput("a5_hold",      16'(data_out_e),   16'(8'hA5));

    // 0x01 with wrong even parity.
    send_frame("x01", 8'h01, 1'b0, 1'b1, 0, 1'b0);

    // 0x3C with a low stop bit; the low stop must not start a new frame.
    send_frame("x3c", 8'h3C, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 0);
    checkOutput("x3c_idle_busy", 16'(busy_e),      16'(0));
    checkOutput("x3c_hold_ferr", 16'(frame_err_e), 16'(1));
    checkOutput("x3c_hold_data", 16'(data_out_e),  16'(8'h3C));
    checkOutput("x3c_no_dv",     16'(data_valid_e), 16'(0));
    sin_valid = 1'b0;

    // Reset in the middle of a frame, after four data bits.
    mid = 8'h5A;
    applyStimulus(1'b0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(mid[i], 0);
    checkOutput("mid_busy", 16'(busy_e), 16'(1));
    sin_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 16'(busy_e),       16'(0));
    checkOutput("mid_rst_dv",   16'(data_valid_e), 16'(0));
    checkOutput("mid_rst_data", 16'(data_out_e),   16'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame("x5a", 8'h5A, 1'b0, 1'b1, 0, 1'b0);

    // Back-to-back 0xFF then 0x00 with the strobe held high throughout.
    send_frame("bb_ff", 8'hFF, 1'b0, 1'b1, 0, 1'b1);
    send_frame("bb_00", 8'h00, 1'b0, 1'b1, 0, 1'b1);
    applyStimulus(1'b1, 0);
    checkOutput("bb_single_pulse", 16'(data_valid_e), 16'(0));
    sin_valid = 1'b0;

    // 0x00 with parity bit 1 and random strobe gaps (odd-correct).
    send_frame("odd00", 8'h00, 1'b1, 1'b1, 4, 1'b0);

    // Randomized frames: mostly correct, some parity and stop errors.
    for (int n = 0; n < 24; n++) begin
      d = DATA_W'($urandom);
      p = ($urandom_range(0, 3) == 0) ? 1'($urandom) : good_pbit(d, 0);
      s = ($urandom_range(0, 6) != 0);
      repeat ($urandom_range(0, 2)) applyStimulus(1'b1, 1);
      send_frame($sformatf("rnd%0d", n), d, p, s, 3, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checkOutput("pulses_even", 16'(pulses_e), 16'(exp_frames));
    checkOutput("pulses_odd",  16'(pulses_o), 16'(exp_frames));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
